// File: rtl/simd_pkg.sv
// Shared definitions for the packed SIMD lane adder: mode encodings and
// per-lane saturation limits as functions of the lane width.
package simd_pkg;

    typedef enum logic [1:0] {
        MODE_WADD = 2'b00,
        MODE_SADD = 2'b01,
        MODE_SSUB = 2'b10,
        MODE_WSUB = 2'b11
    } mode_e;

    // Limits are returned in the low w bits of a 64-bit word; callers truncate.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic is_sub(input logic [1:0] m);
        return (m == MODE_SSUB) || (m == MODE_WSUB);
    endfunction

    function automatic logic is_sat(input logic [1:0] m);
        return (m == MODE_SADD) || (m == MODE_SSUB);
    endfunction

endpackage

// File: rtl/simd_lane_adder_if.sv
// Stream interface of the SIMD lane adder: valid/ready input beat carrying two
// packed operands plus mode, and a valid/ready result beat with overflow flags.
interface simd_lane_adder_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
);
    localparam int DW = LANES * LANE_W;

    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in1;
    logic [DW-1:0]     in2;
    logic [1:0]        mode;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out;
    logic [LANES-1:0]  out_ovf;

    modport master (
        output in_valid, in1, in2, mode, out_ready,
        input  in_ready, out_valid, out, out_ovf
    );

    modport slave (
        input  in_valid, in1, in2, mode, out_ready,
        output in_ready, out_valid, out, out_ovf
    );
endinterface

// File: rtl/simd_lane_alu.sv
// One lane of the adder. The raw half forms the (LANE_W+1)-bit sum/difference;
// the resolve half turns a registered raw value into the wrapped/saturated lane.
module simd_lane_alu
    import simd_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic [1:0]        mode,
    output logic [LANE_W:0]   raw,
    input  logic [LANE_W:0]   raw_q,
    input  logic [1:0]        mode_q,
    output logic [LANE_W-1:0] res,
    output logic              ovf
);
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(sat_max(LANE_W));
    localparam logic [LANE_W-1:0] LANE_MIN = LANE_W'(sat_min(LANE_W));

    logic [LANE_W:0] a_ext;
    logic [LANE_W:0] b_ext;

    assign a_ext = {a[LANE_W-1], a};
    assign b_ext = {b[LANE_W-1], b};
    assign raw   = is_sub(mode) ? (a_ext - b_ext) : (a_ext + b_ext);

    // Bit LANE_W is the true sign of the extended result, so it picks the rail.
    assign ovf = raw_q[LANE_W] != raw_q[LANE_W-1];
    assign res = (is_sat(mode_q) && ovf) ? (raw_q[LANE_W] ? LANE_MIN : LANE_MAX)
                                         : raw_q[LANE_W-1:0];
endmodule

// File: rtl/simd_lane_adder.sv
// Two-stage pipelined packed SIMD add/sub with per-lane wrap/saturate and
// valid/ready backpressure. Optional overflow counter: SIMD_LANE_ADDER_OVF_CNT_EN.
module simd_lane_adder
    import simd_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int DW     = LANES * LANE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    simd_lane_adder_if.slave   bus
`ifdef SIMD_LANE_ADDER_OVF_CNT_EN
    ,
    input  logic               cnt_clr,
    output logic [15:0]        ovf_cnt
`endif
);
    logic                          s1_valid;
    logic [1:0]                    s1_mode;
    logic [LANES-1:0][LANE_W:0]    s1_raw;
    logic [LANES-1:0][LANE_W:0]    raw_d;
    logic [LANES-1:0][LANE_W-1:0]  res_d;
    logic [LANES-1:0]              ovf_d;
    logic                          s2_adv;
    logic                          s1_adv;

    assign s2_adv       = !bus.out_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        simd_lane_alu #(.LANE_W(LANE_W)) u_alu (
            .a      (bus.in1[k*LANE_W +: LANE_W]),
            .b      (bus.in2[k*LANE_W +: LANE_W]),
            .mode   (bus.mode),
            .raw    (raw_d[k]),
            .raw_q  (s1_raw[k]),
            .mode_q (s1_mode),
            .res    (res_d[k]),
            .ovf    (ovf_d[k])
        );
    end

    // Each stage only loads when the stage after it frees up, so a stalled
    // output register holds its data and flags untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_mode       <= MODE_WADD;
            s1_raw        <= '0;
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.out_ovf   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_raw  <= raw_d;
                    s1_mode <= bus.mode;
                end
            end
            if (s2_adv) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out     <= DW'(res_d);
                    bus.out_ovf <= ovf_d;
                end
            end
        end
    end

`ifdef SIMD_LANE_ADDER_OVF_CNT_EN
    logic counted_xfer;

    assign counted_xfer = bus.out_valid && bus.out_ready && (|bus.out_ovf);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= 16'd0;
        end else if (cnt_clr) begin
            ovf_cnt <= 16'd0;
        end else if (counted_xfer && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_simd_lane_adder.sv
// Testbench for simd_lane_adder: table vectors plus random streams through a
// scoreboard, with reset, latency, backpressure and optional counter sequences.
module tb_simd_lane_adder;
    import simd_pkg::*;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int DW     = LANES * LANE_W;

    typedef struct packed {
        logic [DW-1:0]    out;
        logic [LANES-1:0] ovf;
    } exp_t;

    typedef struct {
        logic [DW-1:0]    in1;
        logic [DW-1:0]    in2;
        logic [1:0]       mode;
        logic [DW-1:0]    exp_out;
        logic [LANES-1:0] exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    simd_lane_adder_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

`ifdef SIMD_LANE_ADDER_OVF_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] ovf_cnt;
`endif

    simd_lane_adder #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef SIMD_LANE_ADDER_OVF_CNT_EN
        ,
        .cnt_clr (cnt_clr),
        .ovf_cnt (ovf_cnt)
`endif
    );

    vec_t             vecs[9];
    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [DW-1:0]    cur_out = '0;
    logic [LANES-1:0] cur_ovf = '0;
    logic             held_stall = 1'b0;
    logic [DW-1:0]    held_out = '0;
    logic [LANES-1:0] held_ovf = '0;
    logic             bp_en = 1'b0;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t refModel(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] m);
        exp_t e;
        e = '0;
        for (int k = 0; k < LANES; k++) begin
            int sa, sbv, r;
            logic lane_ovf;
            sa  = int'($signed(a[k*LANE_W +: LANE_W]));
            sbv = int'($signed(b[k*LANE_W +: LANE_W]));
            r   = (m == 2'b10 || m == 2'b11) ? (sa - sbv) : (sa + sbv);
            lane_ovf = (r > 127) || (r < -128);
            e.ovf[k] = lane_ovf;
            if ((m == 2'b01 || m == 2'b10) && lane_ovf)
                e.out[k*LANE_W +: LANE_W] = (r > 0) ? 8'h7F : 8'h80;
            else
                e.out[k*LANE_W +: LANE_W] = 8'(r);
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [1:0] m, input exp_t e);
        logic acc;
        acc = 1'b0;
        bus.in1      = a;
        bus.in2      = b;
        bus.mode     = m;
        cur_out      = e.out;
        cur_ovf      = e.ovf;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL input accept timeout: got in_ready 0, expected 1");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending beats, expected 0", sb.size());
        end
    endtask

    // Scoreboard: queue on accepted input beats, pop on output transfers.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("reset out_valid", DW'(bus.out_valid), '0);
            checkOutput("reset out", bus.out, '0);
            checkOutput("reset out_ovf", DW'(bus.out_ovf), '0);
            sb.delete();
            held_stall = 1'b0;
        end else begin
            if (held_stall) begin
                checkOutput("stall out_valid", DW'(bus.out_valid), DW'(1));
                checkOutput("stall out held", bus.out, held_out);
                checkOutput("stall ovf held", DW'(bus.out_ovf), DW'(held_ovf));
            end
            checkOutput("in_ready", DW'(bus.in_ready),
                        DW'(!(bus.out_valid && !bus.out_ready && sb.size() >= 2)));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected output: got %h, expected no beat", bus.out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("result out", bus.out, e.out);
                    checkOutput("result out_ovf", DW'(bus.out_ovf), DW'(e.ovf));
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(exp_t'({cur_out, cur_ovf}));
            held_stall = bus.out_valid && !bus.out_ready;
            held_out   = bus.out;
            held_ovf   = bus.out_ovf;
        end
    end

    initial begin
        vecs[0] = '{32'h7F8010FF, 32'h01FF2001, 2'b01, 32'h7F803000, 4'b1100};
        vecs[1] = '{32'h7F8010FF, 32'h01FF2001, 2'b00, 32'h807F3000, 4'b1100};
        vecs[2] = '{32'h8000057F, 32'h018006FF, 2'b10, 32'h807FFF7F, 4'b1101};
        vecs[3] = '{32'h8000057F, 32'h018006FF, 2'b11, 32'h7F80FF80, 4'b1101};
        vecs[4] = '{32'h01020304, 32'h10203040, 2'b00, 32'h11223344, 4'b0000};
        vecs[5] = '{32'h7F7F7F7F, 32'h7F7F7F7F, 2'b01, 32'h7F7F7F7F, 4'b1111};
        vecs[6] = '{32'h00000000, 32'h80808080, 2'b10, 32'h7F7F7F7F, 4'b1111};
        vecs[7] = '{32'h00000000, 32'h01010101, 2'b11, 32'hFFFFFFFF, 4'b0000};
        vecs[8] = '{32'hFFFFFFFF, 32'h01010101, 2'b00, 32'h00000000, 4'b0000};

        // Reset held with a beat already offered; it must enter on the first high cycle.
        bus.out_ready = 1'b1;
        bus.in1       = vecs[0].in1;
        bus.in2       = vecs[0].in2;
        bus.mode      = vecs[0].mode;
        cur_out       = vecs[0].exp_out;
        cur_ovf       = vecs[0].exp_ovf;
        bus.in_valid  = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("latency cycle1 out_valid", DW'(bus.out_valid), '0);
        @(posedge clk);
        #1;
        checkOutput("latency cycle2 out_valid", DW'(bus.out_valid), DW'(1));
        checkOutput("first beat out", bus.out, vecs[0].exp_out);
        waitDrain();

        for (int i = 0; i < 9; i++)
            applyStimulus(vecs[i].in1, vecs[i].in2, vecs[i].mode,
                          exp_t'({vecs[i].exp_out, vecs[i].exp_ovf}));
        waitDrain();

        // In-flight beats are dropped by a mid-stream reset.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            logic [DW-1:0] a, b;
            a = $urandom;
            b = $urandom;
            applyStimulus(a, b, 2'b01, refModel(a, b, 2'b01));
        end
        rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", DW'(bus.out_valid), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Backpressure with out_ready cycling 1,0,0,1.
        bp_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [DW-1:0] a, b;
                    logic [1:0] m;
                    a = $urandom;
                    b = $urandom;
                    m = 2'($urandom_range(0, 3));
                    applyStimulus(a, b, m, refModel(a, b, m));
                end
                bp_en = 1'b0;
            end
            begin
                logic [3:0] pat;
                int k;
                pat = 4'b1001;
                k = 0;
                while (bp_en) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = pat[k % 4];
                    k++;
                end
            end
        join
        bus.out_ready = 1'b1;
        waitDrain();

`ifdef SIMD_LANE_ADDER_OVF_CNT_EN
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checkOutput("ovf_cnt cleared", DW'(ovf_cnt), '0);
        for (int i = 0; i < 3; i++)
            applyStimulus(vecs[0].in1, vecs[0].in2, vecs[0].mode,
                          exp_t'({vecs[0].exp_out, vecs[0].exp_ovf}));
        for (int i = 0; i < 2; i++)
            applyStimulus(vecs[4].in1, vecs[4].in2, vecs[4].mode,
                          exp_t'({vecs[4].exp_out, vecs[4].exp_ovf}));
        waitDrain();
        @(posedge clk);
        #1;
        checkOutput("ovf_cnt count", DW'(ovf_cnt), DW'(3));

        bus.out_ready = 1'b0;
        applyStimulus(vecs[0].in1, vecs[0].in2, vecs[0].mode,
                      exp_t'({vecs[0].exp_out, vecs[0].exp_ovf}));
        for (int n = 0; n < 20; n++) begin
            if (bus.out_valid) break;
            @(posedge clk);
            #1;
        end
        cnt_clr       = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checkOutput("ovf_cnt clear wins", DW'(ovf_cnt), '0);
        waitDrain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simd_lane_adder.md
Name: simd_lane_adder

Overview:
- Parametrised, pipelined successor to the fixed 4x8-bit packed adder.
- Adds or subtracts LANES independent signed lanes of LANE_W bits packed into one word.
- Per-lane mode is wrap or saturate, with per-lane overflow flags.
- Uses a valid/ready stream handshake with backpressure. Sits in the accelerator datapath between the conv MAC output and the activation stage.

Parameters:
- LANES, 4, number of packed lanes (>=1).
- LANE_W, 8, bits per lane, two's complement (>=2).
- DW, LANES*LANE_W, derived packed data width; not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in1  in  DW  packed operand A; lane k = bits [k*LANE_W +: LANE_W].
- in2  in  DW  packed operand B.
- mode  in  2  00 wrap add, 01 sat add, 10 sat sub (A-B), 11 wrap sub.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts.
- out  out  DW  packed result.
- out_ovf  out  LANES  per-lane overflow flag for this beat.

Behaviour:
- Reset values: out_valid=0, out=0, out_ovf=0. Stage valids are cleared, so in_ready=1 after reset.
- A beat transfers on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
- Pipeline has two register stages.
  - S1 captures, per lane, the sign-extended (LANE_W+1)-bit sum or difference, plus the mode.
  - S2 holds the final result and is the output register.
- Latency is 2 cycles from input transfer to out_valid; throughput is 1 beat/cycle with no bubbles while out_ready=1.
- Stall rules:
  - S2 advances when !out_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = !s1_valid || S2 advances (combinational from out_ready; no combinational path from in_valid).
- Data and out_ovf are held stable while out_valid && !out_ready.
- Arithmetic per lane: r = A ± B at LANE_W+1 bits; ovf = (r[LANE_W] != r[LANE_W-1]).
  - Wrap modes: out lane = r[LANE_W-1:0]; ovf is still reported.
  - Sat modes on ovf: positive overflow -> 0x7F..F, negative overflow -> 0x80..0. Without ovf: r[LANE_W-1:0].
- Lanes never interact; there is no carry across lane boundaries.
- mode is sampled with its beat; changing mode mid-stream affects only later beats.
- Reset mid-operation drops in-flight beats with no output. The first beat after reset is accepted in the first cycle rst_n is high.
- Simultaneous output transfer and input transfer in the same cycle is legal, with no loss or duplication.

Optional Feature:
- Macro: SIMD_LANE_ADDER_OVF_CNT_EN.
- When defined, the block adds these ports:
  - cnt_clr  in  1  synchronous clear.
  - ovf_cnt  out  16  count of output transfers with |out_ovf.
- ovf_cnt saturates at 0xFFFF and is reset to 0.
- If cnt_clr and a counted transfer occur in the same cycle, the clear wins and the result is 0.
- When not defined, the ports and logic are absent; nothing else changes.

Decomposition:
- Shared package/include simd_pkg holds:
  - mode encodings (MODE_WADD=2'b00, MODE_SADD=2'b01, MODE_SSUB=2'b10, MODE_WSUB=2'b11);
  - sat-max/sat-min constant helpers as functions of LANE_W.
- One sub-module, simd_lane_alu, is combinational: for one lane it takes A, B, mode and produces the LANE_W+1 raw result, the saturated/wrapped result and ovf.
- simd_lane_alu is instantiated LANES times via generate. The top level owns the handshake and both pipeline registers.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out=0, out_ovf=0. First beat after release emerges exactly 2 cycles after transfer.
- LANES=4, LANE_W=8, sat add, in1=0x7F8010FF, in2=0x01FF2001 -> out=0x7F803000, out_ovf=4'b1100.
- Same operands, wrap add -> out=0x807F3000, out_ovf=4'b1100.
- Sat sub, in1=0x8000057F, in2=0x018006FF -> out=0x807FFF7F, out_ovf=4'b1101.
- Backpressure: stream 8 beats with out_ready toggling 1,0,0,1 -> all 8 results arrive in order with none lost or duplicated. out is stable while stalled, and in_ready=0 only when both stages are full and out_ready=0.
- With SIMD_LANE_ADDER_OVF_CNT_EN: 3 overflowing and 2 clean transfers -> ovf_cnt=3. Asserting cnt_clr in the same cycle as an overflowing transfer -> ovf_cnt=0.
